// File: rtl/sd_host_pkg.sv
// Shared Clock Control definitions for the SD host clock path: register bit
// positions, clock FSM states and the frequency-select decode.
package sd_host_pkg;

    localparam int CLK_INT_EN     = 0;
    localparam int CLK_INT_STABLE = 1;
    localparam int CLK_SD_EN      = 2;
    localparam int CLK_FREQ_LSB   = 8;
    localparam int HP_W           = 7;

    typedef enum logic [2:0] {
        ST_OFF         = 3'd0,
        ST_STABILIZING = 3'd1,
        ST_READY       = 3'd2,
        ST_RUNNING     = 3'd3,
        ST_STOPPING    = 3'd4
    } clk_state_e;

    // Highest set bit k selects H = 2^k; 0x00 behaves like 0x01. Returns H-1.
    function automatic logic [HP_W-1:0] half_period_m1(input logic [7:0] freq_sel);
        logic [7:0] half;
        half = 8'd1;
        for (int i = 0; i < 8; i++) begin
            if (freq_sel[i]) begin
                half = 8'd1 << i;
            end
        end
        return HP_W'(half - 8'd1);
    endfunction

endpackage

// File: rtl/sd_clk_divider.sv
// SDCLK half-period counter and toggle flop with registered rise/fall strobes.
// load latches the half-period and restarts low; no_rise lets only falls through.
module sd_clk_divider
    import sd_host_pkg::*;
(
    input  logic            ex_clk,
    input  logic            ex_reset,
    input  logic            load,
    input  logic            clear,
    input  logic            enable,
    input  logic            no_rise,
    input  logic [HP_W-1:0] half_m1_in,
    output logic            sd_clk,
    output logic            sd_clk_rise,
    output logic            sd_clk_fall
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic [HP_W-1:0] half_m1_q, half_m1_d;
    logic            clk_q, clk_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    always_comb begin
        cnt_d     = cnt_q;
        half_m1_d = half_m1_q;
        clk_d     = clk_q;
        if (load) begin
            half_m1_d = half_m1_in;
            cnt_d     = '0;
            clk_d     = 1'b0;
        end else if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            // The counter wraps at H-1 even when a suppressed rise leaves the clock low.
            if (cnt_q == half_m1_q) begin
                cnt_d = '0;
                if (clk_q) begin
                    clk_d = 1'b0;
                end else if (!no_rise) begin
                    clk_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + HP_W'(1);
            end
        end
        rise_d = !clk_q && clk_d;
        fall_d = clk_q && !clk_d;
    end

    // Reset value of half_m1 = 0 corresponds to a latched half-period of 1.
    always_ff @(posedge ex_clk or negedge ex_reset) begin
        if (!ex_reset) begin
            cnt_q     <= '0;
            half_m1_q <= '0;
            clk_q     <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            half_m1_q <= half_m1_d;
            clk_q     <= clk_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign sd_clk      = clk_q;
    assign sd_clk_rise = rise_q;
    assign sd_clk_fall = fall_q;

endmodule

// File: rtl/sd_clk_gen.sv
// SDCLK generator: internal-clock stabilisation, power-of-two division and
// glitch-free start/stop. Optional idle auto-gating via `SDCLK_AUTO_GATE_EN.
module sd_clk_gen
    import sd_host_pkg::*;
#(
    parameter int STABLE_CYCLES    = 16,
    parameter int IDLE_GATE_CYCLES = 8
) (
    input  logic        ex_clk,
    input  logic        ex_reset,
    input  logic [15:0] clk_ctrl_in,
    input  logic        bus_busy,
    output logic        sd_clk,
    output logic        sd_clk_rise,
    output logic        sd_clk_fall,
    output logic        int_clk_stable,
    output logic        sd_clk_active
);

    localparam int STAB_W      = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int STAB_TARGET = (STABLE_CYCLES > 2) ? STABLE_CYCLES - 1 : 1;

    clk_state_e  state_q, state_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d, stab_inc;
    logic        stable_q, stable_d;
    logic        int_en, sd_en;
    logic        gated;
    logic        div_load, div_clear, div_enable, div_no_rise;
    logic        unused_ctrl;

    assign int_en      = clk_ctrl_in[CLK_INT_EN];
    assign sd_en       = clk_ctrl_in[CLK_SD_EN];
    assign stab_inc    = stab_cnt_q + STAB_W'(1);
    assign unused_ctrl = ^{clk_ctrl_in[7:3], clk_ctrl_in[CLK_INT_STABLE]};

`ifdef SDCLK_AUTO_GATE_EN
    localparam int IDLE_W = $clog2(IDLE_GATE_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    assign gated = (idle_cnt_q == IDLE_W'(IDLE_GATE_CYCLES));

    always_comb begin
        idle_cnt_d = '0;
        if (state_q == ST_RUNNING && !bus_busy) begin
            idle_cnt_d = gated ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge ex_clk or negedge ex_reset) begin
        if (!ex_reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_gate_cfg;

    assign gated           = 1'b0;
    assign unused_gate_cfg = bus_busy ^ (IDLE_GATE_CYCLES > 0);
`endif

    always_comb begin
        state_d    = state_q;
        stab_cnt_d = '0;
        case (state_q)
            ST_OFF: begin
                if (int_en) state_d = ST_STABILIZING;
            end
            ST_STABILIZING: begin
                stab_cnt_d = stab_inc;
                if (!int_en) begin
                    state_d = ST_OFF;
                end else if (stab_inc == STAB_W'(STAB_TARGET)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (!int_en) begin
                    state_d = ST_OFF;
                end else if (sd_en) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (!int_en || !sd_en) state_d = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (!sd_clk) state_d = int_en ? ST_READY : ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase

        stable_d = int_en && (state_d inside {ST_READY, ST_RUNNING, ST_STOPPING});

        // Rises are only allowed while the FSM stays in RUNNING, so a stop never
        // opens a new high phase and an existing one always completes.
        div_load    = (state_q == ST_READY) && (state_d == ST_RUNNING);
        div_enable  = (state_q == ST_RUNNING) || (state_q == ST_STOPPING);
        div_no_rise = (state_q != ST_RUNNING) || (state_d != ST_RUNNING);
        div_clear   = 1'b0;
        if (gated && state_q == ST_RUNNING) begin
            div_no_rise = 1'b1;
            if (!sd_clk) begin
                div_enable = 1'b0;
                div_clear  = 1'b1;
            end
        end
    end

    always_ff @(posedge ex_clk or negedge ex_reset) begin
        if (!ex_reset) begin
            state_q    <= ST_OFF;
            stab_cnt_q <= '0;
            stable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            stable_q   <= stable_d;
        end
    end

    sd_clk_divider u_divider (
        .ex_clk      (ex_clk),
        .ex_reset    (ex_reset),
        .load        (div_load),
        .clear       (div_clear),
        .enable      (div_enable),
        .no_rise     (div_no_rise),
        .half_m1_in  (half_period_m1(clk_ctrl_in[CLK_FREQ_LSB +: 8])),
        .sd_clk      (sd_clk),
        .sd_clk_rise (sd_clk_rise),
        .sd_clk_fall (sd_clk_fall)
    );

    assign int_clk_stable = stable_q;
    assign sd_clk_active  = (state_q == ST_RUNNING);

endmodule
